// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: core, DMA and BRAM signals of the data-memory port arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic [3:0]        core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;
  logic              core_gnt;
  logic              core_rvalid;
  logic              dma_req;
  logic [3:0]        dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_dout,
    output core_stall, core_gnt, core_rvalid,
    output dma_gnt, dma_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_dout,
    input  core_stall, core_gnt, core_rvalid,
    input  dma_gnt, dma_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the dmem BRAM port between core MW stage and DMA.
// Core has priority; a starvation counter opens a bounded DMA priority window.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int DMA_BURST    = 8
) (
  input logic clk,
  input logic rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = (DMA_BURST > 1) ? $clog2(DMA_BURST) : 1;

  typedef enum logic {NORMAL, DMA_PRIO} state_t;

  state_t            state;
  logic [SW-1:0]     starve_cnt;
  logic [BW-1:0]     burst_cnt;
  logic              rd_pend;
  logic              rd_owner;
  logic              dma_prio;
  logic              core_gnt;
  logic              dma_gnt;
  logic [3:0]        win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_din;

  always_comb begin
    dma_prio = (state == DMA_PRIO);
    core_gnt = bus.core_req & (~dma_prio | ~bus.dma_req);
    dma_gnt  = bus.dma_req & (dma_prio | ~bus.core_req);
  end

  always_comb begin
    win_we   = '0;
    win_addr = '0;
    win_din  = '0;
    unique case (1'b1)
      core_gnt: begin
        win_we   = bus.core_we;
        win_addr = bus.core_addr;
        win_din  = bus.core_wdata;
      end
      dma_gnt: begin
        win_we   = bus.dma_we;
        win_addr = bus.dma_addr;
        win_din  = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.dma_gnt     = dma_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.mem_en      = core_gnt | dma_gnt;
  assign bus.mem_we      = win_we;
  assign bus.mem_addr    = win_addr;
  assign bus.mem_din     = win_din;
  assign bus.rdata       = bus.mem_dout;
  assign bus.core_rvalid = rd_pend & ~rd_owner;
  assign bus.dma_rvalid  = rd_pend & rd_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pend  <= (core_gnt & (bus.core_we == 4'd0)) |
                  (dma_gnt & (bus.dma_we == 4'd0));
      rd_owner <= dma_gnt;

      if (!bus.dma_req || dma_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      case (state)
        NORMAL: begin
          if (bus.dma_req && !dma_gnt &&
              starve_cnt == SW'(STARVE_LIMIT - 1)) begin
            state     <= DMA_PRIO;
            burst_cnt <= '0;
          end
        end
        DMA_PRIO: begin
          burst_cnt <= burst_cnt + 1'b1;
          // window closes early once the DMA stops asking
          if (!bus.dma_req || burst_cnt == BW'(DMA_BURST - 1)) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            burst_cnt  <= '0;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: random + directed stimulus against a reference model,
// read results checked by a scoreboard monitor.
module tb_dmem_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  dmem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .DMA_BURST(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we == 4'd0)
        bus.mem_dout <= mem[bus.mem_addr];
      else
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
    end
  end

  typedef struct {
    bit            dma;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int streak = 0;
  int wleft = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // scoreboard monitor: rvalid must appear exactly when a read result is due
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      bit ec, ed;
      ec = 1'b0;
      ed = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        ec = !e.dma;
        ed = e.dma;
        check("rdata", bus.rdata, e.data);
      end
      check("core_rvalid", bus.core_rvalid, ec);
      check("dma_rvalid", bus.dma_rvalid, ed);
    end
  end

  task automatic idle_inputs();
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
  endtask

  task automatic cycle(
    input bit cr, input logic [3:0] cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
    input bit dr, input logic [3:0] dw, input logic [AW-1:0] da, input logic [DW-1:0] dd
  );
    bit prio, gc, gd;
    logic [3:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(posedge clk);
    #1;
    bus.core_req = cr; bus.core_we = cw; bus.core_addr = ca; bus.core_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
    @(negedge clk);
    prio = (wleft > 0);
    gc = cr && (!prio || !dr);
    gd = dr && !gc;
    check("core_gnt", bus.core_gnt, gc);
    check("dma_gnt", bus.dma_gnt, gd);
    check("core_stall", bus.core_stall, cr && !gc);
    check("mem_en", bus.mem_en, gc || gd);
    we = gc ? cw : (gd ? dw : 4'd0);
    a  = gc ? ca : (gd ? da : '0);
    d  = gc ? cd : (gd ? dd : '0);
    check("mem_we", bus.mem_we, we);
    check("mem_addr", bus.mem_addr, a);
    if (we != 0) check("mem_din", bus.mem_din, d);
    if (gc || gd) begin
      if (we == 0)
        q.push_back('{dma: gd, data: ref_mem[a], due: cyc + 1});
      else
        for (int b = 0; b < 4; b++)
          if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    if (prio) begin
      wleft--;
      if (!dr) wleft = 0;
      streak = 0;
    end else if (dr && !gd) begin
      streak++;
      if (streak == SL) begin
        wleft = DB;
        streak = 0;
      end
    end else begin
      streak = 0;
    end
  endtask

  initial begin
    logic [DW-1:0] orig5;
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'(i * 32'h9E3779B1);
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    orig5 = ref_mem[5];
    bus.mem_dout = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_core_rvalid", bus.core_rvalid, 1'b0);
    check("reset_dma_rvalid", bus.dma_rvalid, 1'b0);
    check("reset_mem_en", bus.mem_en, 1'b0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // reset lands between a DMA read grant and its data cycle
    cycle(0, 0, 0, 0, 1, 0, 14'h20, 0);
    #2;
    rst_n = 1'b0;
    q.delete();
    streak = 0;
    wleft = 0;
    bus.core_req = 1'b1;
    #1;
    check("rst_mid_core_gnt", bus.core_gnt, 1'b1);
    check("rst_mid_dma_gnt", bus.dma_gnt, 1'b0);
    @(posedge clk);
    #1;
    check("rst_mid_dma_rvalid", bus.dma_rvalid, 1'b0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // core-only read
    cycle(1, 0, 14'h10, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_rdata", bus.rdata, 32'hDEADBEEF);
    check("t2_core_rvalid", bus.core_rvalid, 1'b1);

    // continuous contention
    for (int i = 0; i < 14; i++) begin
      cycle(1, 0, AW'(i), 0, 1, 0, AW'(100 + i), 0);
      check("t3_core_gnt", bus.core_gnt, (i < 4 || i >= 12));
    end

    // window reopens; drop dma_req after two DMA grants
    n = 0;
    while (!bus.dma_gnt && n < 10) begin
      cycle(1, 0, AW'(n), 0, 1, 0, AW'(200 + n), 0);
      n++;
    end
    check("t4_window_open", bus.dma_gnt, 1'b1);
    cycle(1, 0, 14'h1, 0, 1, 0, 14'h2, 0);
    check("t4_second_dma", bus.dma_gnt, 1'b1);
    cycle(1, 0, 14'h3, 0, 0, 0, 0, 0);
    check("t4_core_back", bus.core_gnt, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, AW'(i), 0, 1, 0, AW'(i), 0);
      check("t4_starve_cleared", bus.core_gnt, 1'b1);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // DMA partial write then core read of the same word
    cycle(0, 0, 0, 0, 1, 4'b0011, 14'h5, 32'h12345678);
    check("t5_mem_we", bus.mem_we, 4'b0011);
    cycle(1, 0, 14'h5, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_rdata", bus.rdata, {orig5[31:16], 16'h5678});

    // alternating pipelined reads
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cycle(1, 0, AW'(300 + i), 0, 0, 0, 0, 0);
      else            cycle(0, 0, 0, 0, 1, 0, AW'(400 + i), 0);
    end

    // random traffic over a small address window
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0,
            AW'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0,
            AW'($urandom_range(0, 15)), $urandom);
    end

    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
